scalar_mult_ctrl: RTL and testbench

Sequencer for elliptic-curve scalar multiplication R = k·P using MSB-first double-and-add. It drives one point-doubling unit and one point-addition unit through their Reset/Done handshake. It also owns the special cases those units cannot handle: point at infinity, P+P, and P+(−P). It sits above the point_add/point_double datapath and below the ECDSA signing/verification control.

---
 rtl/scalar_mult_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Double-and-add sequencer for EC scalar multiplication R = k*P (MSB first).
// Drives one point-doubling and one point-addition unit and resolves infinity, P+P and P+(-P) itself.
module scalar_mult_ctrl #(
   parameter int WIDTH   = 256,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] P_x,
   input  logic [WIDTH-1:0] P_y,
   output logic             busy,
   output logic             Done,
   output logic             Err,
   output logic [WIDTH-1:0] R_x,
   output logic [WIDTH-1:0] R_y,
   output logic             R_inf,
   output logic             dbl_Reset,
   output logic [WIDTH-1:0] dbl_x,
   output logic [WIDTH-1:0] dbl_y,
   input  logic             dbl_Done,
   input  logic [WIDTH-1:0] dbl_Rx,
   input  logic [WIDTH-1:0] dbl_Ry,
   output logic             add_Reset,
   output logic [WIDTH-1:0] add_Px,
   output logic [WIDTH-1:0] add_Py,
   output logic [WIDTH-1:0] add_Qx,
   output logic [WIDTH-1:0] add_Qy,
   input  logic             add_Done,
   input  logic [WIDTH-1:0] add_Rx,
   input  logic [WIDTH-1:0] add_Ry
);

   localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
   localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIT,
      S_DBL,
      S_DBL2,
      S_ADD,
      S_NEXT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_kr;
   logic [WIDTH-1:0] r_bx;
   logic [WIDTH-1:0] r_by;
   logic [WIDTH-1:0] r_ax;
   logic [WIDTH-1:0] r_ay;
   logic             r_ainf;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_timer;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [WIDTH-1:0] r_rx;
   logic [WIDTH-1:0] r_ry;
   logic             r_rinf;
   logic             r_dbl_rst;
   logic             r_add_rst;

   logic w_bit;
   logic w_tmo;
   logic w_dbl_eqx;
   logic w_dbl_eqy;

   assign w_bit     = r_kr[r_idx];
   assign w_tmo     = (r_timer == TMO_LAST);
   assign w_dbl_eqx = (dbl_Rx == r_bx);
   assign w_dbl_eqy = (dbl_Ry == r_by);

   assign busy      = r_busy;
   assign Done      = r_done;
   assign Err       = r_err;
   assign R_x       = r_rx;
   assign R_y       = r_ry;
   assign R_inf     = r_rinf;
   assign dbl_Reset = r_dbl_rst;
   assign dbl_x     = r_ax;
   assign dbl_y     = r_ay;
   assign add_Reset = r_add_rst;
   assign add_Px    = r_ax;
   assign add_Py    = r_ay;
   assign add_Qx    = r_bx;
   assign add_Qy    = r_by;

   // Every wait state spends its first cycle releasing the unit reset, so each unit
   // sees at least one high cycle between operations and the two resets never overlap.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_kr      <= '0;
         r_bx      <= '0;
         r_by      <= '0;
         r_ax      <= '0;
         r_ay      <= '0;
         r_ainf    <= 1'b0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_rx      <= '0;
         r_ry      <= '0;
         r_rinf    <= 1'b0;
         r_dbl_rst <= 1'b1;
         r_add_rst <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_kr    <= k;
                  r_bx    <= P_x;
                  r_by    <= P_y;
                  r_ainf  <= 1'b1;
                  r_idx   <= IDX_TOP;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_BIT;
               end
            end

            S_BIT: begin
               // Infinity or y=0 both leave an infinite accumulator after doubling;
               // adding B to infinity is just B.
               if (r_ainf || (r_ay == '0)) begin
                  if (w_bit) begin
                     r_ax   <= r_bx;
                     r_ay   <= r_by;
                     r_ainf <= 1'b0;
                  end else begin
                     r_ainf <= 1'b1;
                  end
                  r_state <= S_NEXT;
               end else begin
                  r_timer <= '0;
                  r_state <= S_DBL;
               end
            end

            S_DBL: begin
               if (r_dbl_rst) begin
                  r_dbl_rst <= 1'b0;
                  r_timer   <= '0;
               end else if (dbl_Done) begin
                  r_ax      <= dbl_Rx;
                  r_ay      <= dbl_Ry;
                  r_dbl_rst <= 1'b1;
                  r_timer   <= '0;
                  if (!w_bit) begin
                     r_state <= S_NEXT;
                  end else if (w_dbl_eqx && w_dbl_eqy) begin
                     r_state <= S_DBL2;
                  end else if (w_dbl_eqx) begin
                     r_ainf  <= 1'b1;
                     r_state <= S_NEXT;
                  end else begin
                     r_state <= S_ADD;
                  end
               end else if (w_tmo) begin
                  r_err     <= 1'b1;
                  r_busy    <= 1'b0;
                  r_dbl_rst <= 1'b1;
                  r_add_rst <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end

            S_DBL2: begin
               if (r_dbl_rst) begin
                  r_dbl_rst <= 1'b0;
                  r_timer   <= '0;
               end else if (dbl_Done) begin
                  r_ax      <= dbl_Rx;
                  r_ay      <= dbl_Ry;
                  r_dbl_rst <= 1'b1;
                  r_state   <= S_NEXT;
               end else if (w_tmo) begin
                  r_err     <= 1'b1;
                  r_busy    <= 1'b0;
                  r_dbl_rst <= 1'b1;
                  r_add_rst <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end

            S_ADD: begin
               if (r_add_rst) begin
                  r_add_rst <= 1'b0;
                  r_timer   <= '0;
               end else if (add_Done) begin
                  r_ax      <= add_Rx;
                  r_ay      <= add_Ry;
                  r_add_rst <= 1'b1;
                  r_state   <= S_NEXT;
               end else if (w_tmo) begin
                  r_err     <= 1'b1;
                  r_busy    <= 1'b0;
                  r_dbl_rst <= 1'b1;
                  r_add_rst <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end

            S_NEXT: begin
               if (r_idx == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx - 1'b1;
                  r_state <= S_BIT;
               end
            end

            S_DONE: begin
               r_rx    <= r_ainf ? '0 : r_ax;
               r_ry    <= r_ainf ? '0 : r_ay;
               r_rinf  <= r_ainf;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: stub point units, protocol monitor and a bit-serial
// reference model of double-and-add with the special-case rules.
module tb_scalar_mult_ctrl;

   localparam int W    = 256;
   localparam int TMO  = 300;
   localparam int MAXC = 20000;

   logic         clk = 1'b0;
   logic         Reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] k = '0, P_x = '0, P_y = '0;
   logic         busy, Done, Err, R_inf;
   logic [W-1:0] R_x, R_y;
   logic         dbl_Reset, add_Reset;
   logic [W-1:0] dbl_x, dbl_y, add_Px, add_Py, add_Qx, add_Qy;
   logic         dbl_Done, add_Done;
   logic [W-1:0] dbl_Rx = '0, dbl_Ry = '0, add_Rx = '0, add_Ry = '0;

   logic stub_dd = 1'b0, stub_ad = 1'b0;
   logic stray_d = 1'b0, stray_a = 1'b0, dbl_hang = 1'b0;
   int   dcnt = 0, acnt = 0;
   int   Ld = 3, La = 3;

   // stub behaviour: mode 1 returns fixed points, mode 0 a modular hash
   int           mode = 1;
   logic [W-1:0] modm = 7;
   logic [W-1:0] fdx = '0, fdy = '0, fax = '0, fay = '0;

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   int n_dbl, n_add, dlow, alow, both_low, unstable;
   int dfall_cyc = 0, drise_cyc = 0, gap = -1;
   logic [W-1:0] d0x, d0y, a0px, a0py, a0qx, a0qy;
   logic         pd_rst = 1'b1, pa_rst = 1'b1;
   logic [W-1:0] pdx = '0, pdy = '0, papx = '0, papy = '0, paqx = '0, paqy = '0;

   assign dbl_Done = stub_dd | stray_d;
   assign add_Done = stub_ad | stray_a;

   scalar_mult_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk(clk), .Reset(Reset), .start(start), .k(k), .P_x(P_x), .P_y(P_y),
      .busy(busy), .Done(Done), .Err(Err), .R_x(R_x), .R_y(R_y), .R_inf(R_inf),
      .dbl_Reset(dbl_Reset), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_Done(dbl_Done),
      .dbl_Rx(dbl_Rx), .dbl_Ry(dbl_Ry),
      .add_Reset(add_Reset), .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx),
      .add_Qy(add_Qy), .add_Done(add_Done), .add_Rx(add_Rx), .add_Ry(add_Ry)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [2*W-1:0] sdbl(input logic [W-1:0] x, input logic [W-1:0] y);
      if (mode == 1) return {fdx, fdy};
      return {(x * 3 + y + 1) % modm, (x + y * 2 + 3) % modm};
   endfunction

   function automatic logic [2*W-1:0] sadd(input logic [W-1:0] px, input logic [W-1:0] py,
                                           input logic [W-1:0] qx, input logic [W-1:0] qy);
      if (mode == 1) return {fax, fay};
      return {(px + qx * 5 + py + 2) % modm, (py * 3 + qy + px) % modm};
   endfunction

   always @(posedge clk) begin
      if (dbl_Reset) begin
         stub_dd <= 1'b0;
         dcnt    <= 0;
      end else if (!stub_dd && !dbl_hang) begin
         if (dcnt >= Ld - 1) begin
            stub_dd          <= 1'b1;
            {dbl_Rx, dbl_Ry} <= sdbl(dbl_x, dbl_y);
         end else begin
            dcnt <= dcnt + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (add_Reset) begin
         stub_ad <= 1'b0;
         acnt    <= 0;
      end else if (!stub_ad) begin
         if (acnt >= La - 1) begin
            stub_ad          <= 1'b1;
            {add_Rx, add_Ry} <= sadd(add_Px, add_Py, add_Qx, add_Qy);
         end else begin
            acnt <= acnt + 1;
         end
      end
   end

   // unit-handshake monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!dbl_Reset && !add_Reset) both_low++;
      if (!dbl_Reset) begin
         dlow++;
         if (pd_rst) begin
            if (n_dbl == 0) begin d0x = dbl_x; d0y = dbl_y; end
            n_dbl++;
            dfall_cyc = cyc;
         end else if (dbl_x !== pdx || dbl_y !== pdy) begin
            unstable++;
         end
      end else if (!pd_rst) begin
         drise_cyc = cyc;
      end
      if (!add_Reset) begin
         alow++;
         if (pa_rst) begin
            if (n_add == 0) begin
               a0px = add_Px; a0py = add_Py; a0qx = add_Qx; a0qy = add_Qy;
               gap = cyc - drise_cyc;
            end
            n_add++;
         end else if (add_Px !== papx || add_Py !== papy || add_Qx !== paqx || add_Qy !== paqy) begin
            unstable++;
         end
      end
      pd_rst = dbl_Reset; pdx = dbl_x; pdy = dbl_y;
      pa_rst = add_Reset; papx = add_Px; papy = add_Py; paqx = add_Qx; paqy = add_Qy;
   end

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: walk k MSB first; doubling then optional addition of B,
   // with infinity, y=0, A==B and A==-B handled as the controller must.
   task automatic model(input logic [W-1:0] kk, input logic [W-1:0] bx, input logic [W-1:0] by,
                        output logic [W-1:0] rx, output logic [W-1:0] ry, output logic rinf,
                        output int nd, output int na);
      logic [W-1:0] ax, ay;
      logic         inf;
      ax = '0; ay = '0; inf = 1'b1; nd = 0; na = 0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!inf) begin
            if (ay == '0) inf = 1'b1;
            else begin {ax, ay} = sdbl(ax, ay); nd++; end
         end
         if (kk[i]) begin
            if (inf) begin ax = bx; ay = by; inf = 1'b0; end
            else if (ax == bx && ay == by) begin {ax, ay} = sdbl(ax, ay); nd++; end
            else if (ax == bx) inf = 1'b1;
            else begin {ax, ay} = sadd(ax, ay, bx, by); na++; end
         end
      end
      rinf = inf;
      rx = inf ? '0 : ax;
      ry = inf ? '0 : ay;
   endtask

   task automatic run_job(input logic [W-1:0] kk, input logic [W-1:0] px, input logic [W-1:0] py,
                          input int spur_at, output int cycles);
      @(posedge clk); #1;
      n_dbl = 0; n_add = 0; dlow = 0; alow = 0; both_low = 0; unstable = 0; gap = -1;
      k = kk; P_x = px; P_y = py; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("done_cleared", Done, 0);
      cycles = 0;
      while (!(Done || Err) && cycles < MAXC) begin
         if (spur_at != 0 && cycles == spur_at) begin
            start = 1'b1; k = '0; P_x = 1; P_y = 2;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cycles++;
      end
      chk("job_finished", Done | Err, 1);
   endtask

   initial begin
      int           cycles, nd, na, err_cyc;
      logic [W-1:0] ex, ey, kk, bx, by;
      logic         einf;
      int           mods[4];
      mods = '{5, 7, 13, 65521};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_err", Err, 0);
      chk("rst_rx", R_x, 0);
      chk("rst_rinf", R_inf, 0);
      chk("rst_dbl_reset", dbl_Reset, 1);
      chk("rst_add_reset", add_Reset, 1);
      @(negedge clk) Reset = 1'b0;

      // k=1 with stray unit Done pulses that must be ignored
      stray_d = 1'b1; stray_a = 1'b1;
      run_job(1, 5, 7, 0, cycles);
      stray_d = 1'b0; stray_a = 1'b0;
      chk("k1_cycles", cycles, 2 * W + 1);
      chk("k1_rx", R_x, 5);
      chk("k1_ry", R_y, 7);
      chk("k1_rinf", R_inf, 0);
      chk("k1_busy", busy, 0);
      chk("k1_dlow", dlow, 0);
      chk("k1_alow", alow, 0);

      run_job(0, 5, 7, 0, cycles);
      chk("k0_cycles", cycles, 2 * W + 1);
      chk("k0_rinf", R_inf, 1);
      chk("k0_rx", R_x, 0);
      chk("k0_ry", R_y, 0);
      chk("k0_units", dlow + alow, 0);

      mode = 1; fdx = 9; fdy = 11; fax = 13; fay = 17;
      run_job(3, 5, 7, 0, cycles);
      chk("k3_ndbl", n_dbl, 1);
      chk("k3_nadd", n_add, 1);
      chk("k3_dbl_x", d0x, 5);
      chk("k3_dbl_y", d0y, 7);
      chk("k3_add_px", a0px, 9);
      chk("k3_add_py", a0py, 11);
      chk("k3_add_qx", a0qx, 5);
      chk("k3_add_qy", a0qy, 7);
      chk("k3_rx", R_x, 13);
      chk("k3_ry", R_y, 17);
      chk("k3_gap_ge1", gap >= 1, 1);
      chk("k3_both_low", both_low, 0);
      chk("k3_cycles", cycles, 2 * W + 1 + dlow + 1 + alow + 1);

      // start while busy must not disturb the running job
      run_job(3, 5, 7, 20, cycles);
      chk("spur_rx", R_x, 13);
      chk("spur_ry", R_y, 17);
      chk("spur_ndbl", n_dbl, 1);

      fdx = 5; fdy = 19;
      run_job(3, 5, 7, 0, cycles);
      chk("neg_nadd", n_add, 0);
      chk("neg_rinf", R_inf, 1);
      chk("neg_rx", R_x, 0);

      fdx = 5; fdy = 7;
      run_job(3, 5, 7, 0, cycles);
      chk("dbl2_ndbl", n_dbl, 2);
      chk("dbl2_nadd", n_add, 0);
      chk("dbl2_rx", R_x, 5);
      chk("dbl2_ry", R_y, 7);
      chk("dbl2_rinf", R_inf, 0);

      dbl_hang = 1'b1;
      run_job(3, 5, 7, 0, cycles);
      err_cyc = cyc;
      chk("tmo_err", Err, 1);
      chk("tmo_done", Done, 0);
      chk("tmo_busy", busy, 0);
      chk("tmo_dbl_reset", dbl_Reset, 1);
      chk("tmo_add_reset", add_Reset, 1);
      chk("tmo_latency", err_cyc - dfall_cyc, TMO);

      // asynchronous reset while a doubling is outstanding
      @(posedge clk); #1;
      k = 3; P_x = 5; P_y = 7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 0;
      while (dbl_Reset && cycles < 2000) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk("mid_dbl_reached", dbl_Reset, 0);
      repeat (2) @(posedge clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_err", Err, 0);
      chk("mid_dbl_reset", dbl_Reset, 1);
      chk("mid_dbl_x", dbl_x, 0);
      chk("mid_rx", R_x, 0);
      @(negedge clk);
      Reset = 1'b0;
      dbl_hang = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_dbl_reset", dbl_Reset, 1);

      // randomized jobs against the reference model
      mode = 0;
      for (int r = 0; r < 6; r++) begin
         modm = mods[$urandom_range(0, 3)];
         Ld = $urandom_range(1, 4);
         La = $urandom_range(1, 4);
         bx = $urandom % modm;
         by = $urandom % modm;
         for (int j = 0; j < 8; j++) kk[j * 32 +: 32] = $urandom;
         if (r % 2 == 1) for (int j = 0; j < 8; j++) kk[j * 32 +: 32] &= $urandom;
         model(kk, bx, by, ex, ey, einf, nd, na);
         run_job(kk, bx, by, 0, cycles);
         chk("rnd_rx", R_x, ex);
         chk("rnd_ry", R_y, ey);
         chk("rnd_rinf", R_inf, einf);
         chk("rnd_ndbl", n_dbl, nd);
         chk("rnd_nadd", n_add, na);
         chk("rnd_err", Err, 0);
         chk("rnd_both_low", both_low, 0);
         chk("rnd_unstable", unstable, 0);
         chk("rnd_cycles", cycles, 2 * W + 1 + dlow + alow + nd + na);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
